// File: rtl/demux4_reg.sv
// demux4_reg: 1:4 registered demux, valid/ready, 1-cycle latency; in_ready = selected lane free (or reset),
// lanes drain independently; optional stall counter under DEMUX4_PERF_EN.
module demux4_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX4_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  logic [WIDTH-1:0] r_data [4];
  logic [3:0]       r_vld;
  logic [3:0]       w_free;
  logic [3:0]       w_load;
  logic             w_fire;

  assign w_free   = ~r_vld | out_ready;
  // Offers made during reset see ready but are discarded by the reset branch below.
  assign in_ready = reset | w_free[sel];
  assign w_fire   = in_valid & in_ready;
  assign w_load   = w_fire ? (4'b0001 << sel) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_data[k] <= in_data;
          r_vld[k]  <= 1'b1;
        end else if (out_ready[k]) begin
          r_vld[k]  <= 1'b0;
        end
      end
    end
  end

  assign o0        = r_data[0];
  assign o1        = r_data[1];
  assign o2        = r_data[2];
  assign o3        = r_data[3];
  assign out_valid = r_vld;

`ifdef DEMUX4_PERF_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = in_valid & ~in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_demux4_reg.sv
// Directed bench for demux4_reg: reset, lane steering, backpressure isolation,
// back-to-back throughput, parallel drain, reset priority, optional stall counter.
module tb_demux4_reg;

  logic        clk;
  logic        reset;
  logic [63:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] o0, o1, o2, o3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
`ifdef DEMUX4_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  demux4_reg #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX4_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [1:0] s, input logic [63:0] d);
    in_valid = 1'b1;
    sel      = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    tick();
    // Word offered during reset: ready, but dropped
    offer(2'd1, 64'd99);
    check("ready_in_reset", in_ready, 1);
    tick();
    reset = 1'b0; in_valid = 1'b0; #1;
    check("rst_out_valid", out_valid, 4'b0000);
    check("rst_o0", o0, 0);
    check("rst_o1", o1, 0);
    check("rst_o2", o2, 0);
    check("rst_o3", o3, 0);

    // Single load to lane 2
    offer(2'd2, 64'hDEAD_BEEF);
    check("t1_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; #1;
    check("t1_o2", o2, 64'hDEAD_BEEF);
    check("t1_valid", out_valid, 4'b0100);
    check("t1_o0", o0, 0);
    check("t1_o1", o1, 0);
    check("t1_o3", o3, 0);

    // Lane 1 full and stalled; lane 3 still reachable
    offer(2'd1, 64'h55);
    tick();
    offer(2'd1, 64'd5);
    check("t2_ready_blocked", in_ready, 0);
    tick();
    check("t2_o1_kept", o1, 64'h55);
    check("t2_valid_a", out_valid, 4'b0110);
    offer(2'd3, 64'd7);
    check("t2_ready_lane3", in_ready, 1);
    tick();
    in_valid = 1'b0; #1;
    check("t2_valid_b", out_valid, 4'b1110);
    check("t2_o3", o3, 64'd7);
    check("t2_o1_stable", o1, 64'h55);

    // Back-to-back into lane 0 with its consumer always ready
    out_ready = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      offer(2'd0, 64'(i));
      check("t3_ready", in_ready, 1);
      tick();
      check("t3_o0", o0, 64'(i));
      check("t3_valid", out_valid, 4'b1111);
    end
    in_valid = 1'b0; #1;
    tick();
    check("t3_drained", out_valid, 4'b1110);
    check("t3_o0_hold", o0, 64'd4);

    // Drain everything, refill with 10..13, then drain all four at once
    out_ready = 4'b1111; #1;
    tick();
    check("t4_empty", out_valid, 4'b0000);
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      offer(2'(k), 64'(10 + k));
      tick();
    end
    in_valid = 1'b0; #1;
    check("t4_full", out_valid, 4'b1111);
    out_ready = 4'b1111; #1;
    tick();
    out_ready = 4'b0000; #1;
    check("t4_drain_valid", out_valid, 4'b0000);
    check("t4_o0", o0, 64'd10);
    check("t4_o1", o1, 64'd11);
    check("t4_o2", o2, 64'd12);
    check("t4_o3", o3, 64'd13);

    // Stray out_ready on empty lanes does nothing
    out_ready = 4'b1010; #1;
    tick();
    out_ready = 4'b0000; #1;
    check("t4_stray_ready", out_valid, 4'b0000);

    // Reset mid-transfer wins over load
    offer(2'd0, 64'd20);
    tick();
    offer(2'd2, 64'd22);
    tick();
    check("t5_pre_valid", out_valid, 4'b0101);
    reset = 1'b1;
    offer(2'd1, 64'h77);
    check("t5_ready_in_reset", in_ready, 1);
    tick();
    reset = 1'b0; in_valid = 1'b0; #1;
    check("t5_valid", out_valid, 4'b0000);
    check("t5_o0", o0, 0);
    check("t5_o1", o1, 0);
    check("t5_o2", o2, 0);
    check("t5_o3", o3, 0);
    tick();
    check("t5_no_lane1", out_valid, 4'b0000);

`ifdef DEMUX4_PERF_EN
    check("perf_rst", stall_cnt, 0);
    offer(2'd3, 64'd3);
    tick();
    offer(2'd3, 64'd4);
    for (int i = 0; i < 20; i++) tick();
    check("perf_20", stall_cnt, 20);
    force dut.r_stall_cnt = 16'hFFFD;
    #1;
    release dut.r_stall_cnt;
    for (int i = 0; i < 5; i++) tick();
    check("perf_sat", stall_cnt, 16'hFFFF);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0; #1;
    check("perf_clr", stall_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
